// File: rtl/param_fifo.sv
// Synchronous FIFO with any depth >= 2, registered read data and almost-full/almost-empty flags.
// Define FIFO_ERR_FLAGS_EN to add the sticky overflow/underflow flags and err_clr.
module param_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 2,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             wr_en,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             rd_en,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic                             fifo_full,
    output logic                             fifo_empty,
    output logic                             almost_full,
    output logic                             almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
    input  logic                             err_clr,
    output logic                             overflow,
    output logic                             underflow,
`endif
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    localparam logic [PtrW-1:0] LastPtr  = PtrW'(FIFO_DEPTH - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
    localparam logic [CntW-1:0] AfCnt    = CntW'(AF_LEVEL);
    localparam logic [CntW-1:0] AeCnt    = CntW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    logic rd_acc;
    logic wr_acc;
    logic mem_we;

    always_comb begin
        rd_acc   = rd_en && (count_q != '0);
        // A read in the same cycle frees a slot, so a full FIFO still accepts the write.
        wr_acc   = wr_en && ((count_q != DepthCnt) || rd_acc);
        mem_we   = wr_acc && !flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
                dout_d   = mem_q[rd_ptr_q];
            end
            if (wr_acc && !rd_acc) begin
                count_d = count_q + CntW'(1);
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    // Storage is never cleared; validity is tracked by the pointers and count only.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign dout         = dout_q;
    assign fifo_count   = count_q;
    assign fifo_full    = (count_q == DepthCnt);
    assign fifo_empty   = (count_q == '0);
    assign almost_full  = (count_q >= AfCnt);
    assign almost_empty = (count_q <= AeCnt);

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A set event in the same cycle wins over err_clr.
    always_comb begin
        overflow_d  = err_clr ? 1'b0 : overflow_q;
        underflow_d = err_clr ? 1'b0 : underflow_q;
        if (wr_en && !wr_acc && !flush) begin
            overflow_d = 1'b1;
        end
        if (rd_en && (count_q == '0) && !flush) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of wr_data and dout in bits.
REQ-002 Parameter FIFO_DEPTH, default 16, SHALL set the entry count; any value >= 2 is legal, and a power of two SHALL NOT be required.
REQ-003 Parameter AF_LEVEL, default FIFO_DEPTH-2, SHALL set the almost-full threshold; legal range is 1..FIFO_DEPTH.
REQ-004 Parameter AE_LEVEL, default 2, SHALL set the almost-empty threshold; legal range is 0..FIFO_DEPTH-1.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 flush  input  1  SHALL be the synchronous clear request, active high.
REQ-008 wr_en  input  1  SHALL be the write request.
REQ-009 wr_data  input  DATA_WIDTH  SHALL be the write data.
REQ-010 rd_en  input  1  SHALL be the read request.
REQ-011 dout  output  DATA_WIDTH  SHALL be the registered read data.
REQ-012 fifo_full  output  1  SHALL indicate that the FIFO is full.
REQ-013 fifo_empty  output  1  SHALL indicate that the FIFO is empty.
REQ-014 almost_full  output  1  SHALL indicate that occupancy is at or above the almost-full threshold.
REQ-015 almost_empty  output  1  SHALL indicate that occupancy is at or below the almost-empty threshold.
REQ-016 fifo_count  output  $clog2(FIFO_DEPTH+1)  SHALL be the current occupancy, 0..FIFO_DEPTH.
REQ-017 err_clr  input  1  SHALL clear the sticky error flags; this port exists only under FIFO_ERR_FLAGS_EN.
REQ-018 overflow, underflow  output  1 each  SHALL be the sticky error flags; these ports exist only under FIFO_ERR_FLAGS_EN.

Function
REQ-019 Read accept (rd_acc) SHALL be rd_en && fifo_count != 0.
REQ-020 Write accept (wr_acc) SHALL be wr_en && (fifo_count != FIFO_DEPTH || rd_acc), so a simultaneous read and write while full both proceed.
REQ-021 On wr_acc, wr_data SHALL be stored at wr_ptr and wr_ptr SHALL advance.
REQ-022 On rd_acc, dout SHALL load the entry at rd_ptr at that clock edge (one-cycle read latency) and rd_ptr SHALL advance.
REQ-023 dout SHALL hold its value on every cycle without rd_acc.
REQ-024 Each pointer SHALL wrap explicitly from FIFO_DEPTH-1 to 0, with no modulo on the raw binary value.
REQ-025 fifo_count SHALL change by +1 on wr_acc only, by -1 on rd_acc only, and SHALL be unchanged when both or neither occur.
REQ-026 While empty, a simultaneous rd_en and wr_en SHALL accept the write only, with no bypass; dout SHALL be unchanged.
REQ-027 fifo_full SHALL equal (fifo_count == FIFO_DEPTH), combinational from the count register.
REQ-028 fifo_empty SHALL equal (fifo_count == 0), combinational from the count register.
REQ-029 almost_full SHALL equal (fifo_count >= AF_LEVEL).
REQ-030 almost_empty SHALL equal (fifo_count <= AE_LEVEL).
REQ-031 flush SHALL have priority over all operations: pointers and count go to 0 at the next edge, same-cycle wr_en and rd_en are ignored, and dout holds its value.
REQ-032 Storage contents SHALL NOT be reset or cleared; only pointer state determines validity.

Reset
REQ-033 Asserting reset low SHALL immediately clear wr_ptr, rd_ptr, fifo_count and dout to 0, independent of clk.
REQ-034 During and after reset, outputs SHALL be fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0 and overflow=underflow=0.
REQ-035 Reset asserted mid-operation SHALL discard all stored entries, and no write in progress SHALL complete.
REQ-036 Reset release SHALL be synchronous to clk in the integrating design; the first edge after release SHALL operate normally.

Configuration
REQ-037 Macro FIFO_ERR_FLAGS_EN, when defined, SHALL include err_clr, overflow and underflow.
REQ-038 overflow SHALL set on wr_en && !wr_acc && !flush.
REQ-039 underflow SHALL set on rd_en && fifo_count == 0 && !flush.
REQ-040 Each error flag SHALL stay set until err_clr=1, and a set event SHALL have priority over err_clr in the same cycle.
REQ-041 When FIFO_ERR_FLAGS_EN is undefined, the ports and logic from REQ-037 to REQ-040 SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-042 Wrap and ordering (DEPTH=5, DATA_WIDTH=8): write 0x11..0x15, then read 5 times -> dout=0x11..0x15 in order, each one cycle after rd_en; full=1 at count 5; empty=1 at the end.
REQ-043 Non-power-of-2 wrap (DEPTH=5): run 12 interleaved write/read pairs -> data order preserved, count never exceeds 5, pointers pass through 4->0 twice.
REQ-044 Full simultaneous (DEPTH=5, full): rd_en=wr_en=1 with wr_data=0xA5 -> count stays 5; the oldest entry appears on dout; 0xA5 is read out last among the remaining entries.
REQ-045 Thresholds (DEPTH=16, AF_LEVEL=14, AE_LEVEL=2): fill one entry at a time -> almost_empty=1 for count 0..2, almost_full=1 for count 14..16.
REQ-046 Flush and reset: at count 3, assert flush together with wr_en -> next cycle count=0, empty=1, dout unchanged; assert reset low mid-write -> outputs per REQ-033 and REQ-034 without waiting for a clock edge.
REQ-047 Errors (FIFO_ERR_FLAGS_EN defined): write while full without read -> overflow=1, count unchanged; read while empty -> underflow=1; err_clr=1 -> both clear next cycle.
